l2_wb_drain: RTL

- Downstream consumer of the L2 write buffer. Pops buffered stores one at a time and issues each as a single-word write to the memory-side bus using a req/ack handshake.
- Arbitrates against L2 refill reads.
- Forces a full drain, and holds the L2 refill, when a missing line has dirty words still sitting in the buffer (read-after-write hazard). Also services an explicit flush request.

---
 rtl/l2_wb_drain.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/l2_wb_drain.sv
// Drains the L2 write buffer onto the memory write bus one word at a time.
// Defers to refill reads unless a dirty-line hazard or a flush forces a full drain.
module l2_wb_drain #(
  parameter int DATA_LENGTH = 32,
  parameter int TAG_LENGTH  = 30,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                    clk_l2,
  input  logic                    rst,
  input  logic                    wb_empty,
  input  logic [DATA_LENGTH-1:0]  wb_data_in,
  input  logic [TAG_LENGTH-1:0]   wb_tag_in,
  input  logic                    wb_read_tag_hit,
  output logic                    wb_load,
  input  logic                    l2_miss_req,
  input  logic                    mem_rd_busy,
  input  logic                    flush_req,
  output logic                    miss_hold,
  output logic                    flush_done,
  output logic                    mem_wr_req,
  output logic [TAG_LENGTH+1:0]   mem_wr_addr,
  output logic [DATA_LENGTH-1:0]  mem_wr_data,
  input  logic                    mem_wr_ack,
  output logic                    drain_busy,
  output logic                    err_timeout
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_POP   = 2'd1,
    ST_LATCH = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  state_t                   state_r;
  state_t                   state_next_s;
  logic                     go_s;
  logic                     force_set_s;
  logic                     force_clr_s;
  logic                     force_r;
  logic                     flush_pend_r;
  logic                     flush_done_r;
  logic                     wb_load_r;
  logic                     mem_wr_req_r;
  logic                     drain_busy_r;
  logic                     err_r;
  logic                     err_next_s;
  logic [CNT_W-1:0]         cnt_r;
  logic [CNT_W-1:0]         cnt_next_s;
  logic [TAG_LENGTH+1:0]    addr_r;
  logic [DATA_LENGTH-1:0]   data_r;

  // Drain enable, force episode control and next-state selection.
  always_comb begin
    go_s         = !wb_empty && (force_r || !mem_rd_busy);
    force_set_s  = flush_req || (l2_miss_req && wb_read_tag_hit);
    force_clr_s  = (state_r == ST_IDLE) && wb_empty;
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (go_s) begin
          state_next_s = ST_POP;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_POP:   state_next_s = ST_LATCH;
      ST_LATCH: state_next_s = ST_WRITE;
      ST_WRITE: begin
        if (!mem_wr_ack) begin
          state_next_s = ST_WRITE;
        end else if (go_s) begin
          state_next_s = ST_POP;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Ack watchdog: after ACK_TIMEOUT unacked WRITE cycles, flag and keep retrying.
  always_comb begin
    cnt_next_s = '0;
    err_next_s = 1'b0;
    if ((state_r == ST_WRITE) && !mem_wr_ack) begin
      if (cnt_r == CNT_LAST) begin
        cnt_next_s = '0;
        err_next_s = 1'b1;
      end else begin
        cnt_next_s = cnt_r + CNT_W'(1);
      end
    end else begin
      cnt_next_s = '0;
    end
  end

  // State, registered outputs and the captured write beat.
  always_ff @(posedge clk_l2 or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      wb_load_r    <= 1'b0;
      mem_wr_req_r <= 1'b0;
      drain_busy_r <= 1'b0;
      addr_r       <= '0;
      data_r       <= '0;
      cnt_r        <= '0;
      err_r        <= 1'b0;
      force_r      <= 1'b0;
      flush_pend_r <= 1'b0;
      flush_done_r <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      wb_load_r    <= (state_next_s == ST_POP);
      mem_wr_req_r <= (state_next_s == ST_WRITE);
      drain_busy_r <= (state_next_s != ST_IDLE);
      cnt_r        <= cnt_next_s;
      err_r        <= err_next_s;
      // Buffer read data becomes valid on the edge that leaves POP.
      if (state_r == ST_LATCH) begin
        addr_r <= {wb_tag_in, 2'b00};
        data_r <= wb_data_in;
      end
      if (force_set_s) begin
        force_r <= 1'b1;
      end else if (force_clr_s) begin
        force_r <= 1'b0;
      end
      if (flush_req) begin
        flush_pend_r <= 1'b1;
      end else if (force_clr_s && !force_set_s) begin
        flush_pend_r <= 1'b0;
      end
      flush_done_r <= force_r && flush_pend_r && force_clr_s && !force_set_s;
    end
  end

  assign wb_load     = wb_load_r;
  assign mem_wr_req  = mem_wr_req_r;
  assign mem_wr_addr = addr_r;
  assign mem_wr_data = data_r;
  assign drain_busy  = drain_busy_r;
  assign err_timeout = err_r;
  assign miss_hold   = force_r;
  assign flush_done  = flush_done_r;

endmodule
